execute_memory_stage: RTL and testbench



---
 rtl/execute_memory_stage.sv | 161 ++++++++++++++++
 tb/tb_execute_memory_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_memory_stage.sv
// EX/MEM pipeline stage: two-entry skid buffer (main M + skid S) carrying the EX payload to MEM.
// Latency: 1 cycle from accept to out_valid when empty; strict FIFO order through M then S.
// Backpressure: in_ready is the registered !S.valid, so out_ready never reaches in_ready combinationally.
//
// Ports: clk / reset (sync, active-high), flush (drops every held entry and the same-cycle input),
//   in_valid/in_ready and out_valid/out_ready handshakes, *_execute / *_in payload inputs,
//   *_memory / *_out registered payload outputs. The write enables are gated by out_valid.
//   srcB_memory is srcB zero-extended to ADDR_W.
// Optional: define EXMEM_STALL_COUNT_EN to add stall_cycles. It is a saturating 32-bit count of
//   the cycles spent with out_valid && !out_ready, and only reset clears it.
module execute_memory_stage #(
    parameter int SCALAR_W = 8,
    parameter int ADDR_W   = 16,
    parameter int LANES    = 16,
    parameter int LANE_W   = 8,
    parameter int REG_AW   = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    input  logic                      wre_execute,
    input  logic                      vector_wre_execute,
    input  logic                      write_memory_enable_a_execute,
    input  logic                      write_memory_enable_b_execute,
    input  logic [1:0]                select_writeback_data_mux_execute,
    input  logic [1:0]                select_writeback_vector_data_mux_execute,
    input  logic [SCALAR_W-1:0]       ALUresult_in,
    input  logic [LANES*LANE_W-1:0]   ALUvectorResult_in,
    input  logic [REG_AW-1:0]         rs1_execute,
    input  logic [REG_AW-1:0]         rs2_execute,
    input  logic [REG_AW-1:0]         rd_execute,
    input  logic [ADDR_W-1:0]         srcA_execute,
    input  logic [SCALAR_W-1:0]       srcB_execute,
    input  logic [LANES*LANE_W-1:0]   vector_srcB_execute,
    output logic                      wre_memory,
    output logic                      vector_wre_memory,
    output logic                      write_memory_enable_a_memory,
    output logic                      write_memory_enable_b_memory,
    output logic [1:0]                select_writeback_data_mux_memory,
    output logic [1:0]                select_writeback_vector_data_mux_memory,
    output logic [SCALAR_W-1:0]       ALUresult_out,
    output logic [LANES*LANE_W-1:0]   ALUvectorResult_out,
    output logic [REG_AW-1:0]         rs1_memory,
    output logic [REG_AW-1:0]         rs2_memory,
    output logic [REG_AW-1:0]         rd_memory,
    output logic [ADDR_W-1:0]         srcA_memory,
    output logic [ADDR_W-1:0]         srcB_memory,
    output logic [LANES*LANE_W-1:0]   vector_srcB_memory
`ifdef EXMEM_STALL_COUNT_EN
    ,
    output logic [31:0]               stall_cycles
`endif
);

    typedef struct packed {
        logic                    wre;
        logic                    vwre;
        logic                    wme_a;
        logic                    wme_b;
        logic [1:0]              sel_wb;
        logic [1:0]              sel_vwb;
        logic [SCALAR_W-1:0]     alu;
        logic [LANES*LANE_W-1:0] valu;
        logic [REG_AW-1:0]       rs1;
        logic [REG_AW-1:0]       rs2;
        logic [REG_AW-1:0]       rd;
        logic [ADDR_W-1:0]       src_a;
        logic [SCALAR_W-1:0]     src_b;
        logic [LANES*LANE_W-1:0] vsrc_b;
    } payload_t;

    payload_t in_dat;
    payload_t m_dat;
    payload_t s_dat;
    logic     m_vld;
    logic     s_vld;
    logic     accept;
    logic     emit;

    assign in_dat.wre     = wre_execute;
    assign in_dat.vwre    = vector_wre_execute;
    assign in_dat.wme_a   = write_memory_enable_a_execute;
    assign in_dat.wme_b   = write_memory_enable_b_execute;
    assign in_dat.sel_wb  = select_writeback_data_mux_execute;
    assign in_dat.sel_vwb = select_writeback_vector_data_mux_execute;
    assign in_dat.alu     = ALUresult_in;
    assign in_dat.valu    = ALUvectorResult_in;
    assign in_dat.rs1     = rs1_execute;
    assign in_dat.rs2     = rs2_execute;
    assign in_dat.rd      = rd_execute;
    assign in_dat.src_a   = srcA_execute;
    assign in_dat.src_b   = srcB_execute;
    assign in_dat.vsrc_b  = vector_srcB_execute;

    // Ready depends only on the skid register, so MEM stalls are absorbed by S for one cycle.
    assign in_ready  = !s_vld;
    assign out_valid = m_vld;
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
            m_dat <= '0;
            s_dat <= '0;
        end else if (flush) begin
            // Flush wins over accept and emit; stale data is harmless once the valid bits drop.
            m_vld <= 1'b0;
            s_vld <= 1'b0;
        end else if (accept && (!m_vld || emit)) begin
            m_vld <= 1'b1;
            if (s_vld) begin
                m_dat <= s_dat;
                s_dat <= in_dat;
            end else begin
                m_dat <= in_dat;
            end
        end else if (accept) begin
            // M is occupied and stalled: park the new payload in the skid entry.
            s_dat <= in_dat;
            s_vld <= 1'b1;
        end else if (emit) begin
            m_dat <= s_dat;
            m_vld <= s_vld;
            s_vld <= 1'b0;
        end
    end

    // A bubble in M must never write a register or memory.
    assign wre_memory                   = m_dat.wre   && m_vld;
    assign vector_wre_memory            = m_dat.vwre  && m_vld;
    assign write_memory_enable_a_memory = m_dat.wme_a && m_vld;
    assign write_memory_enable_b_memory = m_dat.wme_b && m_vld;

    assign select_writeback_data_mux_memory        = m_dat.sel_wb;
    assign select_writeback_vector_data_mux_memory = m_dat.sel_vwb;
    assign ALUresult_out       = m_dat.alu;
    assign ALUvectorResult_out = m_dat.valu;
    assign rs1_memory          = m_dat.rs1;
    assign rs2_memory          = m_dat.rs2;
    assign rd_memory           = m_dat.rd;
    assign srcA_memory         = m_dat.src_a;
    assign srcB_memory         = ADDR_W'(m_dat.src_b);
    assign vector_srcB_memory  = m_dat.vsrc_b;

`ifdef EXMEM_STALL_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_execute_memory_stage.sv
module tb_execute_memory_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic         wre_execute;
    logic         vector_wre_execute;
    logic         write_memory_enable_a_execute;
    logic         write_memory_enable_b_execute;
    logic [1:0]   select_writeback_data_mux_execute;
    logic [1:0]   select_writeback_vector_data_mux_execute;
    logic [7:0]   ALUresult_in;
    logic [127:0] ALUvectorResult_in;
    logic [4:0]   rs1_execute;
    logic [4:0]   rs2_execute;
    logic [4:0]   rd_execute;
    logic [15:0]  srcA_execute;
    logic [7:0]   srcB_execute;
    logic [127:0] vector_srcB_execute;
    logic         wre_memory;
    logic         vector_wre_memory;
    logic         write_memory_enable_a_memory;
    logic         write_memory_enable_b_memory;
    logic [1:0]   select_writeback_data_mux_memory;
    logic [1:0]   select_writeback_vector_data_mux_memory;
    logic [7:0]   ALUresult_out;
    logic [127:0] ALUvectorResult_out;
    logic [4:0]   rs1_memory;
    logic [4:0]   rs2_memory;
    logic [4:0]   rd_memory;
    logic [15:0]  srcA_memory;
    logic [15:0]  srcB_memory;
    logic [127:0] vector_srcB_memory;
`ifdef EXMEM_STALL_COUNT_EN
    logic [31:0]  stall_cycles;
`endif

    always #5 clk = ~clk;

    execute_memory_stage dut (
        .clk                                      (clk),
        .reset                                    (reset),
        .flush                                    (flush),
        .in_valid                                 (in_valid),
        .in_ready                                 (in_ready),
        .out_valid                                (out_valid),
        .out_ready                                (out_ready),
        .wre_execute                              (wre_execute),
        .vector_wre_execute                       (vector_wre_execute),
        .write_memory_enable_a_execute            (write_memory_enable_a_execute),
        .write_memory_enable_b_execute            (write_memory_enable_b_execute),
        .select_writeback_data_mux_execute        (select_writeback_data_mux_execute),
        .select_writeback_vector_data_mux_execute (select_writeback_vector_data_mux_execute),
        .ALUresult_in                             (ALUresult_in),
        .ALUvectorResult_in                       (ALUvectorResult_in),
        .rs1_execute                              (rs1_execute),
        .rs2_execute                              (rs2_execute),
        .rd_execute                               (rd_execute),
        .srcA_execute                             (srcA_execute),
        .srcB_execute                             (srcB_execute),
        .vector_srcB_execute                      (vector_srcB_execute),
        .wre_memory                               (wre_memory),
        .vector_wre_memory                        (vector_wre_memory),
        .write_memory_enable_a_memory             (write_memory_enable_a_memory),
        .write_memory_enable_b_memory             (write_memory_enable_b_memory),
        .select_writeback_data_mux_memory         (select_writeback_data_mux_memory),
        .select_writeback_vector_data_mux_memory  (select_writeback_vector_data_mux_memory),
        .ALUresult_out                            (ALUresult_out),
        .ALUvectorResult_out                      (ALUvectorResult_out),
        .rs1_memory                               (rs1_memory),
        .rs2_memory                               (rs2_memory),
        .rd_memory                                (rd_memory),
        .srcA_memory                              (srcA_memory),
        .srcB_memory                              (srcB_memory),
        .vector_srcB_memory                       (vector_srcB_memory)
`ifdef EXMEM_STALL_COUNT_EN
        ,
        .stall_cycles                             (stall_cycles)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One record = inputs for one cycle, then the expected outputs just after that cycle's edge.
    typedef struct {
        logic       iv;
        logic       ordy;
        logic       fl;
        logic [7:0] alu;
        logic [4:0] rd;
        logic       wre;
        logic       e_ov;
        logic       e_ir;
        logic [7:0] e_alu;
        logic [4:0] e_rd;
        logic       e_wre;
    } vec_t;

    vec_t tbl[19];

    initial begin
        logic [127:0] vec_lane;
        logic [127:0] vec_rev;

        // Stream of 4 back-to-back items, then drain.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h5A, 5'd3,  1'b1, 1'b1, 1'b1, 8'h5A, 5'd3,  1'b1};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h11, 5'd4,  1'b0, 1'b1, 1'b1, 8'h11, 5'd4,  1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'h22, 5'd5,  1'b1, 1'b1, 1'b1, 8'h22, 5'd5,  1'b1};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'h33, 5'd6,  1'b1, 1'b1, 1'b1, 8'h33, 5'd6,  1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0,  1'b1, 1'b0, 1'b1, 8'h00, 5'd0,  1'b0};
        // Backpressure: A into M, B into S, C held off, then drain A, B, C in order.
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'hA1, 5'd7,  1'b1, 1'b1, 1'b1, 8'hA1, 5'd7,  1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'hB2, 5'd8,  1'b1, 1'b1, 1'b0, 8'hA1, 5'd7,  1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'hC3, 5'd9,  1'b1, 1'b1, 1'b0, 8'hA1, 5'd7,  1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'hC3, 5'd9,  1'b1, 1'b1, 1'b1, 8'hB2, 5'd8,  1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'hC3, 5'd9,  1'b1, 1'b1, 1'b1, 8'hC3, 5'd9,  1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0,  1'b0, 1'b0, 1'b1, 8'h00, 5'd0,  1'b0};
        // Flush with both entries full plus a presented input; nothing survives.
        tbl[11] = '{1'b1, 1'b0, 1'b0, 8'hD4, 5'd10, 1'b1, 1'b1, 1'b1, 8'hD4, 5'd10, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 8'hE5, 5'd11, 1'b1, 1'b1, 1'b0, 8'hD4, 5'd10, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 8'hF6, 5'd12, 1'b1, 1'b0, 1'b1, 8'h00, 5'd0,  1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0,  1'b0, 1'b0, 1'b1, 8'h00, 5'd0,  1'b0};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 8'h07, 5'd13, 1'b0, 1'b1, 1'b1, 8'h07, 5'd13, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0,  1'b0, 1'b0, 1'b1, 8'h00, 5'd0,  1'b0};
        // Flush on an empty stage drops an input even though in_ready was high.
        tbl[17] = '{1'b1, 1'b1, 1'b1, 8'h08, 5'd14, 1'b1, 1'b0, 1'b1, 8'h00, 5'd0,  1'b0};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0,  1'b0, 1'b0, 1'b1, 8'h00, 5'd0,  1'b0};

        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        wre_execute = 1'b0;
        vector_wre_execute = 1'b0;
        write_memory_enable_a_execute = 1'b0;
        write_memory_enable_b_execute = 1'b0;
        select_writeback_data_mux_execute = 2'd0;
        select_writeback_vector_data_mux_execute = 2'd0;
        ALUresult_in = 8'h00;
        ALUvectorResult_in = '0;
        rs1_execute = 5'd0;
        rs2_execute = 5'd0;
        rd_execute = 5'd0;
        srcA_execute = 16'h0000;
        srcB_execute = 8'h00;
        vector_srcB_execute = '0;
        step();
        step();

        check("reset out_valid", 128'(out_valid), 128'd0);
        check("reset in_ready", 128'(in_ready), 128'd1);
        check("reset wre_memory", 128'(wre_memory), 128'd0);
        check("reset ALUresult_out", 128'(ALUresult_out), 128'd0);
        check("reset srcA_memory", 128'(srcA_memory), 128'd0);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            in_valid     = tbl[i].iv;
            out_ready    = tbl[i].ordy;
            flush        = tbl[i].fl;
            ALUresult_in = tbl[i].alu;
            rd_execute   = tbl[i].rd;
            wre_execute  = tbl[i].wre;
            step();
            check($sformatf("row%0d out_valid", i), 128'(out_valid), 128'(tbl[i].e_ov));
            check($sformatf("row%0d in_ready", i), 128'(in_ready), 128'(tbl[i].e_ir));
            check($sformatf("row%0d wre_memory", i), 128'(wre_memory), 128'(tbl[i].e_wre));
            if (tbl[i].e_ov) begin
                check($sformatf("row%0d ALUresult_out", i), 128'(ALUresult_out), 128'(tbl[i].e_alu));
                check($sformatf("row%0d rd_memory", i), 128'(rd_memory), 128'(tbl[i].e_rd));
            end
        end
        flush = 1'b0;

        // Full-width payload: zero-extension of srcB and bit-exact vector lanes.
        for (int i = 0; i < 16; i++) begin
            vec_lane[i*8 +: 8] = 8'(i);
            vec_rev[i*8 +: 8]  = 8'(15 - i);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        wre_execute = 1'b1;
        vector_wre_execute = 1'b1;
        write_memory_enable_a_execute = 1'b1;
        write_memory_enable_b_execute = 1'b1;
        select_writeback_data_mux_execute = 2'b10;
        select_writeback_vector_data_mux_execute = 2'b01;
        ALUresult_in = 8'h9C;
        ALUvectorResult_in = vec_rev;
        rs1_execute = 5'd1;
        rs2_execute = 5'd2;
        rd_execute = 5'd31;
        srcA_execute = 16'h1234;
        srcB_execute = 8'hF3;
        vector_srcB_execute = vec_lane;
        step();
        check("wide srcA_memory", 128'(srcA_memory), 128'h1234);
        check("wide srcB_memory", 128'(srcB_memory), 128'h00F3);
        check("wide vector_srcB", vector_srcB_memory, 128'h0F0E0D0C0B0A09080706050403020100);
        check("wide ALUvectorResult", ALUvectorResult_out, 128'h000102030405060708090A0B0C0D0E0F);
        check("wide rs1_memory", 128'(rs1_memory), 128'd1);
        check("wide rs2_memory", 128'(rs2_memory), 128'd2);
        check("wide rd_memory", 128'(rd_memory), 128'd31);
        check("wide sel_wb", 128'(select_writeback_data_mux_memory), 128'd2);
        check("wide sel_vwb", 128'(select_writeback_vector_data_mux_memory), 128'd1);
        check("wide vector_wre", 128'(vector_wre_memory), 128'd1);
        check("wide wme_a", 128'(write_memory_enable_a_memory), 128'd1);
        check("wide wme_b", 128'(write_memory_enable_b_memory), 128'd1);
        // The following bubble must not write anything.
        in_valid = 1'b0;
        step();
        check("bubble out_valid", 128'(out_valid), 128'd0);
        check("bubble vector_wre", 128'(vector_wre_memory), 128'd0);
        check("bubble wme_a", 128'(write_memory_enable_a_memory), 128'd0);
        check("bubble wme_b", 128'(write_memory_enable_b_memory), 128'd0);
        check("bubble wre", 128'(wre_memory), 128'd0);

        // Reset mid-stream with both entries full and an input presented.
        out_ready = 1'b0;
        in_valid = 1'b1;
        ALUresult_in = 8'h61;
        step();
        ALUresult_in = 8'h62;
        step();
        check("prefill in_ready", 128'(in_ready), 128'd0);
        reset = 1'b1;
        ALUresult_in = 8'h63;
        step();
        check("midreset out_valid", 128'(out_valid), 128'd0);
        check("midreset in_ready", 128'(in_ready), 128'd1);
        check("midreset ALUresult_out", 128'(ALUresult_out), 128'd0);
        check("midreset ALUvectorResult", ALUvectorResult_out, 128'd0);
        check("midreset srcA_memory", 128'(srcA_memory), 128'd0);
        check("midreset srcB_memory", 128'(srcB_memory), 128'd0);
        check("midreset vector_srcB", vector_srcB_memory, 128'd0);
        check("midreset rd_memory", 128'(rd_memory), 128'd0);
        check("midreset sel_wb", 128'(select_writeback_data_mux_memory), 128'd0);
        check("midreset enables", 128'({wre_memory, vector_wre_memory,
              write_memory_enable_a_memory, write_memory_enable_b_memory}), 128'd0);
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("postreset%0d out_valid", i), 128'(out_valid), 128'd0);
        end

`ifdef EXMEM_STALL_COUNT_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("stall after reset", 128'(stall_cycles), 128'd0);
        out_ready = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        check("stall count 7", 128'(stall_cycles), 128'd7);
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        step();
        check("stall after flush", 128'(stall_cycles), 128'd7);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("stall cleared by reset", 128'(stall_cycles), 128'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
